// File: rtl/exit_occupancy_tracker.sv
// Exit-side beam-sensor FSM plus lot occupancy counter.
// Detects a car leaving (b, both, a, clear) and tracks occupancy from entry/exit pulses.
module exit_occupancy_tracker #(
    parameter int CAPACITY = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ab,
    input  logic             entry,
    output logic             y,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    // State encoding equals the sensor pattern expected while in that state.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        B_CUT  = 2'b01,
        BOTH   = 2'b11,
        A_ONLY = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    state_t           state_q, state_d;
    logic             y_q, y_d;
    logic             err_q, err_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic exit_evt;
    logic illegal;
    logic overflow;
    logic underflow;

    always_comb begin
        state_d  = state_q;
        exit_evt = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ab == 2'b01) state_d = B_CUT;
            end
            B_CUT: begin
                case (ab)
                    2'b11:   state_d = BOTH;
                    2'b00:   state_d = IDLE;
                    2'b10: begin
                        state_d = IDLE;
                        illegal = 1'b1;
                    end
                    default: state_d = B_CUT;
                endcase
            end
            BOTH: begin
                case (ab)
                    2'b10:   state_d = A_ONLY;
                    2'b01:   state_d = B_CUT;
                    2'b00: begin
                        state_d = IDLE;
                        illegal = 1'b1;
                    end
                    default: state_d = BOTH;
                endcase
            end
            A_ONLY: begin
                case (ab)
                    2'b00: begin
                        state_d  = IDLE;
                        exit_evt = 1'b1;
                    end
                    2'b11:   state_d = BOTH;
                    2'b01: begin
                        state_d = IDLE;
                        illegal = 1'b1;
                    end
                    default: state_d = A_ONLY;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous entry and exit cancel out, so neither can overflow or underflow.
    always_comb begin
        count_d   = count_q;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (entry && !exit_evt) begin
            if (count_q < CAP) count_d = count_q + 1'b1;
            else               overflow = 1'b1;
        end else if (exit_evt && !entry) begin
            if (count_q != '0) count_d = count_q - 1'b1;
            else               underflow = 1'b1;
        end
        y_d     = exit_evt;
        err_d   = illegal | overflow | underflow;
        empty_d = (count_d == '0);
        full_d  = (count_d == CAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            err_q   <= err_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign y     = y_q;
    assign err   = err_q;
    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: tb/tb_exit_occupancy_tracker.sv
// Directed bench for exit_occupancy_tracker: vector table for the main flow,
// hand-written sequences for saturation, simultaneous events and mid-sequence reset.
module tb_exit_occupancy_tracker;

    localparam int CAPACITY = 15;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       ab;
    logic             entry;
    logic             y;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             err;

    int num_checks;
    int num_fails;

    typedef struct packed {
        logic [1:0]       ab;
        logic             entry;
        logic             exp_y;
        logic [CNT_W-1:0] exp_count;
        logic             exp_err;
    } vec_t;

    vec_t vecs[$];

    exit_occupancy_tracker #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .ab    (ab),
        .entry (entry),
        .y     (y),
        .count (count),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input logic rst, input logic [1:0] a, input logic ent);
        @(negedge clk);
        reset = rst;
        ab    = a;
        entry = ent;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string sig, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s.%s actual=%0d required=%0d", tag, sig, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ey, input logic [CNT_W-1:0] ec,
                               input logic eerr);
        cmp(tag, "y",     {{(CNT_W-1){1'b0}}, y},     {{(CNT_W-1){1'b0}}, ey});
        cmp(tag, "count", count, ec);
        cmp(tag, "empty", {{(CNT_W-1){1'b0}}, empty}, {{(CNT_W-1){1'b0}}, (ec == '0)});
        cmp(tag, "full",  {{(CNT_W-1){1'b0}}, full},  {{(CNT_W-1){1'b0}}, (ec == CNT_W'(CAPACITY))});
        cmp(tag, "err",   {{(CNT_W-1){1'b0}}, err},   {{(CNT_W-1){1'b0}}, eerr});
    endtask

    task automatic step(input string tag, input logic rst, input logic [1:0] a, input logic ent,
                        input logic ey, input logic [CNT_W-1:0] ec, input logic eerr);
        applyStimulus(rst, a, ent);
        checkOutput(tag, ey, ec, eerr);
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;
        reset = 1'b1;
        ab    = 2'b00;
        entry = 1'b0;

        // ab, entry, y, count, err
        vecs.push_back({2'b00, 1'b1, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b00, 1'b1, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b00, 1'b1, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b11, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b11, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b10, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b10, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b11, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b10, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b11, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b10, 1'b0, 1'b0, 4'd2, 1'b1});
        vecs.push_back({2'b10, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b11, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b10, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b11, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b0, 4'd1, 1'b1});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b11, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b10, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd1, 1'b1});
        vecs.push_back({2'b01, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back({2'b00, 1'b0, 1'b0, 4'd1, 1'b0});

        $display("[TB] reset and vector table (%0d rows)", vecs.size());
        step("reset", 1'b1, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), 1'b0, vecs[i].ab, vecs[i].entry,
                 vecs[i].exp_y, vecs[i].exp_count, vecs[i].exp_err);
        end

        $display("[TB] saturation at capacity");
        step("sat_rst", 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= CAPACITY; i++) begin
            step($sformatf("sat_in%0d", i), 1'b0, 2'b00, 1'b1, 1'b0, CNT_W'(i), 1'b0);
        end
        step("sat_ovf",  1'b0, 2'b00, 1'b1, 1'b0, 4'd15, 1'b1);
        step("sat_hold", 1'b0, 2'b00, 1'b0, 1'b0, 4'd15, 1'b0);
        step("sat_x1",   1'b0, 2'b01, 1'b0, 1'b0, 4'd15, 1'b0);
        step("sat_x2",   1'b0, 2'b11, 1'b0, 1'b0, 4'd15, 1'b0);
        step("sat_x3",   1'b0, 2'b10, 1'b0, 1'b0, 4'd15, 1'b0);
        step("sat_x4",   1'b0, 2'b00, 1'b0, 1'b1, 4'd14, 1'b0);

        $display("[TB] exit from empty lot");
        step("udf_rst", 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        step("udf_x1",  1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
        step("udf_x2",  1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        step("udf_x3",  1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0);
        step("udf_x4",  1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b1);
        step("udf_end", 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("[TB] simultaneous entry and exit");
        step("sim_rst", 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("sim_in%0d", i), 1'b0, 2'b00, 1'b1, 1'b0, CNT_W'(i), 1'b0);
        end
        step("sim_x1", 1'b0, 2'b01, 1'b0, 1'b0, 4'd5, 1'b0);
        step("sim_x2", 1'b0, 2'b11, 1'b0, 1'b0, 4'd5, 1'b0);
        step("sim_x3", 1'b0, 2'b10, 1'b0, 1'b0, 4'd5, 1'b0);
        step("sim_x4", 1'b0, 2'b00, 1'b1, 1'b1, 4'd5, 1'b0);
        step("sim_end", 1'b0, 2'b00, 1'b0, 1'b0, 4'd5, 1'b0);

        $display("[TB] reset while in BOTH");
        step("mid_rst0", 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step($sformatf("mid_in%0d", i), 1'b0, 2'b00, 1'b1, 1'b0, CNT_W'(i), 1'b0);
        end
        step("mid_b",    1'b0, 2'b01, 1'b0, 1'b0, 4'd7, 1'b0);
        step("mid_both", 1'b0, 2'b11, 1'b0, 1'b0, 4'd7, 1'b0);
        step("mid_rst",  1'b1, 2'b11, 1'b1, 1'b0, 4'd0, 1'b0);
        step("mid_a",    1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0);
        step("mid_clr",  1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        step("mid_idle", 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
